decode_stage_p: RTL
===================

# decode_stage_p

Parametrised ID stage and ID/EX pipeline register for the 5-stage RISC-V core. It decodes RV32I/RV32E integer, load/store, branch, jump, LUI and AUIPC instructions, and holds the architectural register file. It registers all control, operand and immediate fields into the EX stage. Compared with the previous decode stage it adds:
- configurable register count and data width
- a stall (hold) input
- shifts, SLT/SLTU, LUI and AUIPC decode
- an illegal-instruction flag
- an optional write-back read bypass

## Interface
Reset is synchronous and active-low: `clk`, `rst_n`.

Parameters:
- XLEN, 32, datapath width of operands, immediates and PC fields (32 or 64).
- NREGS, 32, architectural register count; only 32 (RV32I) or 16 (RV32E) are legal.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- stallD  in  1  hold ID/EX register contents.
- flushE  in  1  load bubble into ID/EX register.
- regwriteW  in  1  write-back enable.
- rdW  in  5  write-back destination index.
- resultW  in  XLEN  write-back data.
- instrD  in  32  instruction in ID.
- pcD, pc4D  in  XLEN  PC and PC+4 of instrD.
- rs1D, rs2D  out  5  combinational instrD[19:15], instrD[24:20], for the hazard unit.
- regwriteE, memrwE, branchE, jumpE, brunE, aselE, bselE, illegalE  out  1  registered controls.
- wbselE  out  2  00 mem, 01 ALU, 10 PC+4.
- aluselE  out  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu, 10 passB.
- funct3E  out  3  registered funct3.
- rdE, rs1E, rs2E  out  5  registered indices.
- rd1E, rd2E, imm_exE, pcE, pc4E  out  XLEN  registered operands, immediate and PCs.

## Operation
- Decode is combinational from instrD; each supported opcode uses its standard RISC-V immediate format.
- Immediates are sign-extended to XLEN. U-type is instr[31:12]<<12, sign-extended from bit 31.
- Control per opcode:
  - R-type: regwrite, wbsel=01, bsel=0. funct7[5] selects sub/sra.
  - I-ALU: bsel=1. SLLI/SRLI/SRAI use shamt = imm[4:0] (imm[5:0] when XLEN=64).
  - Load: wbsel=00.
  - Store: memrw=1, regwrite=0.
  - Branch: branch=1, bsel=1, asel=1 (PC). brun=1 for BLTU/BGEU.
  - JAL: asel=1, bsel=1, jump=1, wbsel=10.
  - JALR: bsel=1, jump=1, wbsel=10.
  - LUI: alusel=passB, bsel=1.
  - AUIPC: asel=1, bsel=1, alusel=add.
- Illegal instruction: any unsupported opcode or funct3, or any rs1/rs2/rd index ≥ NREGS when NREGS=16. This sets illegal=1 and forces regwrite, memrw, branch and jump to 0.
- Register file:
  - NREGS×XLEN.
  - Written on the rising edge when regwriteW && rdW!=0 && rdW<NREGS.
  - Index 0 always reads 0.
  - Reads of index ≥ NREGS return 0.

## Timing
- Latency from ID to EX is one cycle. Outputs change only on the rising edge of clk.
- Edge priority: !rst_n > flushE > stallD > load.
  - rst_n=0: the register file and every registered output go to 0 at the edge, including illegalE=0, wbselE=00 and aluselE=0. A reset asserted mid-operation takes effect at the next edge only.
  - flushE=1: every ID/EX field goes to 0 (a NOP bubble), even if stallD=1.
  - stallD=1, flushE=0: every ID/EX field holds its value.
- Register file writes proceed independently of stallD and flushE.
- Simultaneous write and read of the same index in one cycle is governed by the macro under Configuration.

## Configuration
- DECODE_WB_BYPASS_EN defined: when regwriteW && rdW==rs1D (or rs2D) && rdW!=0, rd1 (rd2) takes resultW in that same cycle. The ID/EX register captures the new value.
- DECODE_WB_BYPASS_EN undefined: reads return the pre-write value. The hazard unit must forward from WB or stall one cycle.

## Test plan
- Reset: hold rst_n=0 for 2 edges with regwriteW=1 → all outputs 0 and the register file unchanged-zero. Changing rst_n between edges produces no output change.
- Write x5=0xDEADBEEF, then decode `add x7,x5,x0` (0x000283B3) → next edge: rd1E=0xDEADBEEF, rd2E=0, aluselE=0, wbselE=01, regwriteE=1, rdE=7.
- Same-cycle write x5=0x12345678 with decode of `addi x6,x5,1` → rd1E=0x12345678 with the macro defined, old x5 without it; imm_exE=1.
- Decode `auipc x1,0xFFFFF` at pcD=0x100 → imm_exE=0xFFFFF000 (sign-extended to XLEN), aselE=1, bselE=1, aluselE=0. Then hold stallD=1 for 3 cycles while changing instrD → E outputs held.
- Decode `beq` with stallD=1 and flushE=1 → all E fields 0. Then decode `bltu` (funct3=110) → branchE=1, brunE=1, funct3E=6.
- NREGS=16: decode `add x17,x1,x2` → illegalE=1, regwriteE=0. A write with rdW=20 leaves all registers unchanged.

Source files
------------

// File: rtl/decode_stage_p.sv
// decode_stage_p: RV32I/RV32E instruction decode, architectural register file
// and ID/EX pipeline register for the 5-stage RISC-V core.
// Optional feature macro: DECODE_WB_BYPASS_EN (same-cycle write-back read bypass).
module decode_stage_p #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stallD,
   input  logic            flushE,
   input  logic            regwriteW,
   input  logic [4:0]      rdW,
   input  logic [XLEN-1:0] resultW,
   input  logic [31:0]     instrD,
   input  logic [XLEN-1:0] pcD,
   input  logic [XLEN-1:0] pc4D,
   output logic [4:0]      rs1D,
   output logic [4:0]      rs2D,
   output logic            regwriteE,
   output logic            memrwE,
   output logic            branchE,
   output logic            jumpE,
   output logic            brunE,
   output logic            aselE,
   output logic            bselE,
   output logic            illegalE,
   output logic [1:0]      wbselE,
   output logic [3:0]      aluselE,
   output logic [2:0]      funct3E,
   output logic [4:0]      rdE,
   output logic [4:0]      rs1E,
   output logic [4:0]      rs2E,
   output logic [XLEN-1:0] rd1E,
   output logic [XLEN-1:0] rd2E,
   output logic [XLEN-1:0] imm_exE,
   output logic [XLEN-1:0] pcE,
   output logic [XLEN-1:0] pc4E
);

   localparam int AW = (NREGS == 16) ? 4 : 5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef struct packed {
      logic            regwrite;
      logic            memrw;
      logic            branch;
      logic            jump;
      logic            brun;
      logic            asel;
      logic            bsel;
      logic            illegal;
      logic [1:0]      wbsel;
      logic [3:0]      alusel;
      logic [2:0]      funct3;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
   } idex_t;

   // Indices 16..31 do not exist in an RV32E register file.
   function automatic logic idx_ok(input logic [4:0] idx);
      return (NREGS == 32) || (idx[4] == 1'b0);
   endfunction

   // ALU operation for the shared R-type / I-ALU funct3 space; alt is funct7[5].
   function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? 4'd1 : 4'd0;
         3'b001:  return 4'd5;
         3'b010:  return 4'd8;
         3'b011:  return 4'd9;
         3'b100:  return 4'd4;
         3'b101:  return alt ? 4'd7 : 4'd6;
         3'b110:  return 4'd3;
         3'b111:  return 4'd2;
         default: return 4'd0;
      endcase
   endfunction

   logic [XLEN-1:0]   regs_r [NREGS];
   logic [6:0]        opcode_s;
   logic [2:0]        funct3_s;
   logic [4:0]        rd_s;
   logic              we_s;
   logic [XLEN-1:0]   rd1_s, rd2_s;
   logic              regwrite_s, memrw_s, branch_s, jump_s, brun_s, asel_s, bsel_s;
   logic              legal_s, use_rs1_s, use_rs2_s, use_rd_s, idx_bad_s, illegal_s;
   logic [1:0]        wbsel_s;
   logic [3:0]        alusel_s;
   logic signed [31:0] imm32_s;
   logic [XLEN-1:0]   imm_s;
   logic              sh5_s;
   idex_t             idex_r;

   assign rs1D     = instrD[19:15];
   assign rs2D     = instrD[24:20];
   assign rd_s     = instrD[11:7];
   assign opcode_s = instrD[6:0];
   assign funct3_s = instrD[14:12];
   assign sh5_s    = (XLEN == 64) ? instrD[25] : 1'b0;
   assign we_s     = regwriteW && (rdW != 5'd0) && idx_ok(rdW);
   assign imm_s    = XLEN'(imm32_s);
   assign idx_bad_s = (use_rs1_s && !idx_ok(rs1D)) || (use_rs2_s && !idx_ok(rs2D)) ||
                      (use_rd_s && !idx_ok(rd_s));
   assign illegal_s = !legal_s || idx_bad_s;

   // Register file: cleared by reset, written independently of stall and flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
      end else if (we_s) begin
         regs_r[rdW[AW-1:0]] <= resultW;
      end
   end

   // Operand read: x0 and nonexistent registers read zero; optional WB bypass.
   always_comb begin
      rd1_s = '0;
      rd2_s = '0;
      if ((rs1D != 5'd0) && idx_ok(rs1D)) rd1_s = regs_r[rs1D[AW-1:0]];
      else rd1_s = '0;
      if ((rs2D != 5'd0) && idx_ok(rs2D)) rd2_s = regs_r[rs2D[AW-1:0]];
      else rd2_s = '0;
`ifdef DECODE_WB_BYPASS_EN
      if (we_s && (rdW == rs1D)) rd1_s = resultW;
      else rd1_s = rd1_s;
      if (we_s && (rdW == rs2D)) rd2_s = resultW;
      else rd2_s = rd2_s;
`endif
   end

   // Control and immediate decode from the opcode and funct3 of instrD.
   always_comb begin
      regwrite_s = 1'b0; memrw_s = 1'b0; branch_s = 1'b0; jump_s = 1'b0;
      brun_s = 1'b0; asel_s = 1'b0; bsel_s = 1'b0; wbsel_s = 2'b00;
      alusel_s = ALU_ADD; imm32_s = '0; legal_s = 1'b1;
      use_rs1_s = 1'b0; use_rs2_s = 1'b0; use_rd_s = 1'b0;
      case (opcode_s)
         OP_R: begin
            regwrite_s = 1'b1; wbsel_s = 2'b01;
            use_rs1_s = 1'b1; use_rs2_s = 1'b1; use_rd_s = 1'b1;
            alusel_s = alu_op(funct3_s, instrD[30]);
         end
         OP_I: begin
            regwrite_s = 1'b1; wbsel_s = 2'b01; bsel_s = 1'b1;
            use_rs1_s = 1'b1; use_rd_s = 1'b1;
            alusel_s = alu_op(funct3_s, (funct3_s == 3'b101) && instrD[30]);
            // Shift immediates carry only the shift amount, not the funct7 bits.
            if ((funct3_s == 3'b001) || (funct3_s == 3'b101))
               imm32_s = {26'd0, sh5_s, instrD[24:20]};
            else
               imm32_s = {{20{instrD[31]}}, instrD[31:20]};
         end
         OP_LOAD: begin
            regwrite_s = 1'b1; wbsel_s = 2'b00; bsel_s = 1'b1;
            use_rs1_s = 1'b1; use_rd_s = 1'b1;
            imm32_s = {{20{instrD[31]}}, instrD[31:20]};
            case (funct3_s)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
               3'b011, 3'b110: legal_s = (XLEN == 64);
               default: legal_s = 1'b0;
            endcase
         end
         OP_STORE: begin
            memrw_s = 1'b1; bsel_s = 1'b1;
            use_rs1_s = 1'b1; use_rs2_s = 1'b1;
            imm32_s = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            case (funct3_s)
               3'b000, 3'b001, 3'b010: legal_s = 1'b1;
               3'b011: legal_s = (XLEN == 64);
               default: legal_s = 1'b0;
            endcase
         end
         OP_BRANCH: begin
            branch_s = 1'b1; asel_s = 1'b1; bsel_s = 1'b1;
            brun_s = funct3_s[1];
            use_rs1_s = 1'b1; use_rs2_s = 1'b1;
            imm32_s = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25],
                       instrD[11:8], 1'b0};
            legal_s = (funct3_s[2:1] != 2'b01);
         end
         OP_JAL: begin
            regwrite_s = 1'b1; jump_s = 1'b1; asel_s = 1'b1; bsel_s = 1'b1;
            wbsel_s = 2'b10; use_rd_s = 1'b1;
            imm32_s = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20],
                       instrD[30:21], 1'b0};
         end
         OP_JALR: begin
            regwrite_s = 1'b1; jump_s = 1'b1; bsel_s = 1'b1; wbsel_s = 2'b10;
            use_rs1_s = 1'b1; use_rd_s = 1'b1;
            imm32_s = {{20{instrD[31]}}, instrD[31:20]};
            legal_s = (funct3_s == 3'b000);
         end
         OP_LUI: begin
            regwrite_s = 1'b1; wbsel_s = 2'b01; bsel_s = 1'b1;
            alusel_s = ALU_PASSB; use_rd_s = 1'b1;
            imm32_s = {instrD[31:12], 12'd0};
         end
         OP_AUIPC: begin
            regwrite_s = 1'b1; wbsel_s = 2'b01; asel_s = 1'b1; bsel_s = 1'b1;
            use_rd_s = 1'b1;
            imm32_s = {instrD[31:12], 12'd0};
         end
         default: legal_s = 1'b0;
      endcase
   end

   // ID/EX register: reset, then flush bubble, then hold, then load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idex_r <= '0;
      end else if (flushE) begin
         idex_r <= '0;
      end else if (stallD) begin
         idex_r <= idex_r;
      end else begin
         idex_r.regwrite <= regwrite_s && !illegal_s;
         idex_r.memrw    <= memrw_s && !illegal_s;
         idex_r.branch   <= branch_s && !illegal_s;
         idex_r.jump     <= jump_s && !illegal_s;
         idex_r.brun     <= brun_s;
         idex_r.asel     <= asel_s;
         idex_r.bsel     <= bsel_s;
         idex_r.illegal  <= illegal_s;
         idex_r.wbsel    <= wbsel_s;
         idex_r.alusel   <= alusel_s;
         idex_r.funct3   <= funct3_s;
         idex_r.rd       <= rd_s;
         idex_r.rs1      <= rs1D;
         idex_r.rs2      <= rs2D;
         idex_r.rd1      <= rd1_s;
         idex_r.rd2      <= rd2_s;
         idex_r.imm      <= imm_s;
         idex_r.pc       <= pcD;
         idex_r.pc4      <= pc4D;
      end
   end

   assign regwriteE = idex_r.regwrite;
   assign memrwE    = idex_r.memrw;
   assign branchE   = idex_r.branch;
   assign jumpE     = idex_r.jump;
   assign brunE     = idex_r.brun;
   assign aselE     = idex_r.asel;
   assign bselE     = idex_r.bsel;
   assign illegalE  = idex_r.illegal;
   assign wbselE    = idex_r.wbsel;
   assign aluselE   = idex_r.alusel;
   assign funct3E   = idex_r.funct3;
   assign rdE       = idex_r.rd;
   assign rs1E      = idex_r.rs1;
   assign rs2E      = idex_r.rs2;
   assign rd1E      = idex_r.rd1;
   assign rd2E      = idex_r.rd2;
   assign imm_exE   = idex_r.imm;
   assign pcE       = idex_r.pc;
   assign pc4E      = idex_r.pc4;

endmodule
